// File: rtl/regfile_sb_if.sv
// Register-file bus: decode/issue read+issue signals and writeback signals.
// master = pipeline side, slave = register file.
interface regfile_sb_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0]        rd_use;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_rd;
   logic                     iss_ready;
   logic                     wb_en;
   logic [ADDR_W-1:0]        wb_addr;
   logic [DATA_W-1:0]        wb_data;
   logic [ADDR_W:0]          pend_cnt;

   modport master (
      output rd_addr, rd_use, iss_en, iss_rd, wb_en, wb_addr, wb_data,
      input  rd_data, rd_busy, iss_ready, pend_cnt
   );

   modport slave (
      input  rd_addr, rd_use, iss_en, iss_rd, wb_en, wb_addr, wb_data,
      output rd_data, rd_busy, iss_ready, pend_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a per-register
// pending (scoreboard) bit used by issue to detect RAW/WAW hazards.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic          clk,
   input logic          rst_n,
   regfile_sb_if.slave  bus
);
   localparam int CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_eff;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [CNT_W-1:0]    pend_cnt_q;

   logic [ADDR_W-1:0]   rd_a [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]   rd_busy_c;
   logic                iss_ready_c;
   logic                wr_ok;
   logic                iss_ok;
   logic                set_inc;
   logic                clr_dec;

   // Pending as seen this cycle: a same-cycle writeback retires the producer
   // early when bypass is on; register 0 is never pending when hardwired.
   always_comb begin
      pend_eff = pend_q;
      if ((BYPASS != 0) && bus.wb_en)
         pend_eff[bus.wb_addr] = 1'b0;
      if (ZERO_REG != 0)
         pend_eff[0] = 1'b0;
   end

   // Combinational read ports with zero-register and writeback forwarding.
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_a[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
         rd_data_c[i*DATA_W +: DATA_W] = regs_q[rd_a[i]];
         if ((BYPASS != 0) && bus.wb_en && (bus.wb_addr == rd_a[i]))
            rd_data_c[i*DATA_W +: DATA_W] = bus.wb_data;
         if ((ZERO_REG != 0) && (rd_a[i] == '0))
            rd_data_c[i*DATA_W +: DATA_W] = '0;
         rd_busy_c[i] = pend_eff[rd_a[i]];
      end
   end

   // Issue gating: stall on any consumed busy source (RAW) or busy destination (WAW).
   always_comb begin
      iss_ready_c = ~(|(bus.rd_use & rd_busy_c)) & ~pend_eff[bus.iss_rd];
      wr_ok  = bus.wb_en && ((ZERO_REG == 0) || (bus.wb_addr != '0));
      iss_ok = bus.iss_en && iss_ready_c && ((ZERO_REG == 0) || (bus.iss_rd != '0));
   end

   // Next pending vector; a set from issue overrides a clear from writeback.
   always_comb begin
      pend_nxt = pend_q;
      if (wr_ok)
         pend_nxt[bus.wb_addr] = 1'b0;
      if (iss_ok)
         pend_nxt[bus.iss_rd] = 1'b1;
      set_inc = iss_ok && !pend_q[bus.iss_rd];
      clr_dec = wr_ok && pend_q[bus.wb_addr] && !(iss_ok && (bus.iss_rd == bus.wb_addr));
   end

   // Register array, pending bits and running pending count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs_q[r] <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         if (wr_ok)
            regs_q[bus.wb_addr] <= bus.wb_data;
         pend_q     <= pend_nxt;
         pend_cnt_q <= pend_cnt_q + CNT_W'(set_inc) - CNT_W'(clr_dec);
      end
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.rd_busy   = rd_busy_c;
   assign bus.iss_ready = iss_ready_c;
   assign bus.pend_cnt  = pend_cnt_q;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds the following:
  - Configurable width, depth and read-port count.
  - Asynchronous clear.
  - Optional write-to-read bypass.
  - Per-register pending (scoreboard) bits, which let the pipelined core detect RAW/WAW hazards and stall issue.
- Sits between decode/issue (read, issue) and writeback (write) stages.

Parameters:
- DATA_W, 32, register data width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, ≥2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- NUM_RD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending.
- BYPASS, 1, 1 = same-cycle writeback forwarded to reads and pending clear.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_use  in  NUM_RD  port i source is actually consumed by the issuing instruction
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i address has pending producer
- iss_en  in  1  issue request for instruction writing iss_rd
- iss_rd  in  ADDR_W  destination register of issuing instruction
- iss_ready  out  1  issue accepted this cycle if iss_en high
- wb_en  in  1  writeback valid
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers are cleared to 0 and all pending bits to 0.
  - Therefore rd_data=0, rd_busy=0, pend_cnt=0 and iss_ready=1.
  - Reset asserted mid-operation discards all pending state immediately.
- Write: at posedge clk with wb_en=1 and (ZERO_REG=0 or wb_addr≠0): reg[wb_addr]<=wb_data and pend[wb_addr]<=0.
- Reads are combinational, zero latency:
  - If ZERO_REG=1 and the address is 0: data=0.
  - Else if BYPASS=1, wb_en=1 and wb_addr equals the read address: data=wb_data.
  - Otherwise data=reg[addr].
  - With BYPASS=0, the written value is visible the cycle after the write.
- Effective pending, pend_eff[a]:
  - Equals pend[a] AND NOT(BYPASS AND wb_en AND wb_addr==a).
  - Forced 0 for a=0 when ZERO_REG=1.
- rd_busy[i]: pend_eff[rd_addr[i]], regardless of rd_use.
- iss_ready:
  - High when no port i has rd_use[i]=1 with rd_busy[i]=1 (RAW).
  - Also requires pend_eff[iss_rd]=0 (WAW).
  - Purely combinational; no dependence on iss_en.
- Issue: at posedge with iss_en=1 and iss_ready=1 (and iss_rd≠0 when ZERO_REG=1): pend[iss_rd]<=1. If iss_ready=0 the request has no effect; the requester holds and retries.
- Simultaneous issue and writeback to the same register in one cycle: set wins, so pend ends at 1 (new producer owns it), while the register data is still updated.
- pend_cnt:
  - Registered population count of pend.
  - Updates on the same edge as pend: +1 for an accepted set of a previously clear bit, −1 for a clear of a set bit, 0 net when both apply to the same register.
  - Never exceeds NUM_REGS−ZERO_REG.
- Writeback to a non-pending register: data is written, pend stays 0 (legal, e.g. CSR or load replay).
- Out-of-range addresses cannot occur (NUM_REGS is a power of two).

Test Plan:
- Reset then read all ports at addresses 0, 5 and 31 -> rd_data=0, rd_busy=0, pend_cnt=0, iss_ready=1.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF with ZERO_REG=1; then read addr 0 -> 0; pend_cnt unchanged.
- wb_en=1, wb_addr=7, wb_data=0x12345678, with rd_addr[0]=7 in the same cycle -> rd_data[0]=0x12345678 (BYPASS=1). With BYPASS=0 it shows the old value, then 0x12345678 the next cycle.
- Issue iss_rd=3, accepted -> pend_cnt=1. Next cycle rd_addr[1]=3 with rd_use[1]=1 -> rd_busy[1]=1, iss_ready=0, and a held iss_en has no effect. Then wb_addr=3 -> (BYPASS=1) same cycle iss_ready=1, rd_data[1]=wb_data; pend_cnt=0 after the edge.
- Same cycle: issue iss_rd=9 (accepted) and wb_addr=9 while 9 is not pending -> pend[9]=1, reg[9]=wb_data, pend_cnt increments by 1.
- Issue to 4 and 6 (pend_cnt=2), then drop rst_n between clock edges -> pend_cnt=0, rd_busy=0, registers read 0 immediately, without waiting for a clock edge.
